// File: rtl/core_pkg.sv
// Shared types and constants for the core_mc multi-cycle processor.
package core_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_XOR = 3'b011,
    OP_LDI = 3'b100,
    OP_LD  = 3'b101,
    OP_ST  = 3'b110,
    OP_BR  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    BC_ALWAYS = 3'b000,
    BC_Z      = 3'b001,
    BC_NZ     = 3'b010,
    BC_C      = 3'b011,
    BC_HALT   = 3'b111
  } br_cond_e;

  typedef struct packed {
    op_e        op;
    logic [2:0] a;
    logic [2:0] b;
  } instr_t;

  // Branch targets; the core keeps the low PW bits of each entry.
  localparam logic [31:0] BR_LUT [8] = '{
    32'h000, 32'h010, 32'h040, 32'h080, 32'h020, 32'h030, 32'hFFF, 32'h005
  };

endpackage

// File: rtl/core_mc_if.sv
// Data-memory req/ack handshake between core_mc (master) and a memory (slave).
interface core_mc_if #(parameter int DW = 8);
  logic          dmem_req;
  logic          dmem_we;
  logic [DW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;

  modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  input  dmem_rdata, dmem_ack);
  modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
                  output dmem_rdata, dmem_ack);
endinterface

// File: rtl/core_regfile.sv
// 8 x DW register file: two asynchronous read ports, one synchronous write port.
module core_regfile #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [2:0]    rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] regs_q [8];
  logic [DW-1:0] regs_d [8];

  // NOTE: start from the current contents so every path assigns regs_d (no latch).
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
  end

  // NOTE: this array is small flop storage with an architectural reset value of 0,
  // so it is cleared on reset; a RAM macro would not be.
  // NOTE: state updates use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  assign ra_data = regs_q[ra_addr];
  assign rb_data = regs_q[rb_addr];

endmodule

// File: rtl/core_mc.sv
// Multi-cycle 9-bit-ISA core with req/ack data memory and sticky halt.
// Optional retired-instruction counter enabled by CORE_PERF_CNT_EN.
module core_mc
  import core_pkg::*;
#(
  parameter int DW        = 8,
  parameter int PW        = 12,
  parameter int HALT_ADDR = 128
) (
  input  logic          clk,
  input  logic          reset,
  output logic [PW-1:0] imem_addr,
  input  logic [8:0]    imem_data,
  core_mc_if.master     dmem,
  output logic          done,
  output logic [31:0]   instr_count
);

  localparam logic [PW-1:0] HALT_PC = PW'(HALT_ADDR);

  instr_t        ins;
  state_e        state_q, state_d;
  logic [PW-1:0] pc_q, pc_d, pc_inc, br_target;
  logic          z_q, z_d, c_q, c_d, done_q, done_d;
  logic          req_q, req_d, we_q, we_d;
  logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]    dest_q, dest_d;
  logic [DW-1:0] ra_val, rb_val, rf_wdata;
  logic [DW:0]   sum_w, diff_w;
  logic [2:0]    rf_waddr;
  logic          rf_we, taken;

  assign ins       = instr_t'(imem_data);
  assign sum_w     = {1'b0, ra_val} + {1'b0, rb_val};
  assign diff_w    = {1'b0, ra_val} - {1'b0, rb_val};
  assign pc_inc    = pc_q + PW'(1);
  assign br_target = BR_LUT[ins.b][PW-1:0];

  core_regfile #(.DW(DW)) u_regfile (
    .clk     (clk),
    .rst_n   (reset),
    .ra_addr (ins.a),
    .ra_data (ra_val),
    .rb_addr (ins.b),
    .rb_data (rb_val),
    .wr_en   (rf_we),
    .wr_addr (rf_waddr),
    .wr_data (rf_wdata)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    z_d      = z_q;
    c_d      = c_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    dest_d   = dest_q;
    rf_we    = 1'b0;
    rf_waddr = ins.a;
    rf_wdata = '0;
    taken    = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (pc_q == HALT_PC) begin
          state_d = ST_HALT;
        end else begin
          pc_d = pc_inc;
          unique case (ins.op)
            OP_ADD: begin
              rf_we = 1'b1; rf_wdata = sum_w[DW-1:0];
              c_d = sum_w[DW]; z_d = ~|rf_wdata;
            end
            OP_SUB: begin
              rf_we = 1'b1; rf_wdata = diff_w[DW-1:0];
              c_d = diff_w[DW]; z_d = ~|rf_wdata;
            end
            OP_AND: begin
              rf_we = 1'b1; rf_wdata = ra_val & rb_val; z_d = ~|rf_wdata;
            end
            OP_XOR: begin
              rf_we = 1'b1; rf_wdata = ra_val ^ rb_val; z_d = ~|rf_wdata;
            end
            OP_LDI: begin
              rf_we = 1'b1; rf_wdata = DW'(ins.b);
            end
            OP_LD, OP_ST: begin
              // PC stays put until the access is acknowledged.
              pc_d    = pc_q;
              addr_d  = rb_val;
              wdata_d = ra_val;
              we_d    = (ins.op == OP_ST);
              dest_d  = ins.a;
              req_d   = 1'b1;
              state_d = ST_MEM_WAIT;
            end
            OP_BR: begin
              case (ins.a)
                BC_ALWAYS: taken = 1'b1;
                BC_Z:      taken = z_q;
                BC_NZ:     taken = ~z_q;
                BC_C:      taken = c_q;
                BC_HALT: begin
                  pc_d    = pc_q;
                  state_d = ST_HALT;
                end
                default:   taken = 1'b0;
              endcase
              if (taken) pc_d = br_target;
            end
          endcase
        end
      end
      ST_MEM_WAIT: begin
        if (dmem.dmem_ack) begin
          rf_we    = ~we_q;
          rf_waddr = dest_q;
          rf_wdata = dmem.dmem_rdata;
          pc_d     = pc_inc;
          req_d    = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_HALT: ;
      default: state_d = ST_RUN;
    endcase
    done_d = done_q | (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pc_q    <= '0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dest_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      z_q     <= z_d;
      c_q     <= c_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dest_q  <= dest_d;
      done_q  <= done_d;
    end
  end

  assign imem_addr       = pc_q;
  assign done            = done_q;
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;

`ifdef CORE_PERF_CNT_EN
  logic        retire;
  logic [31:0] cnt_q, cnt_d;

  // Retire points: any non-memory op decoded in RUN, or the ack cycle of LD/ST.
  assign retire = (state_q == ST_RUN && pc_q != HALT_PC &&
                   ins.op != OP_LD && ins.op != OP_ST) ||
                  (state_q == ST_MEM_WAIT && dmem.dmem_ack);

  always_comb begin
    cnt_d = cnt_q;
    if (retire && cnt_q != '1) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_core_mc.sv
// Directed-program bench for core_mc: memory transactions checked by a scoreboard.
`timescale 1ns/1ps
module tb_core_mc;
  import core_pkg::*;

  localparam int DW = 8;
  localparam int PW = 12;
  localparam logic [8:0] NOP_I = 9'b111_100_000;
`ifdef CORE_PERF_CNT_EN
  localparam int EXP_T1_CNT = 19;
`else
  localparam int EXP_T1_CNT = 0;
`endif

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] imem_addr;
  logic [8:0]    imem_data;
  logic          done;
  logic [31:0]   instr_count;

  logic [8:0] rom [0:4095];
  logic [7:0] mem [0:255];
  txn_t       exp_q [$];
  txn_t       mon_e;
  int         ack_at  = 1;
  int         req_cnt = 0;
  int         n_vec   = 0;
  int         n_bad   = 0;

  always #5 clk = ~clk;

  core_mc_if #(.DW(DW)) dmem ();

  core_mc #(.DW(DW), .PW(PW), .HALT_ADDR(128)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .dmem        (dmem),
    .done        (done),
    .instr_count (instr_count)
  );

  assign imem_data = rom[imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    return {op, a, b};
  endfunction

  task automatic expect_txn(input logic we, input logic [7:0] addr, input logic [7:0] data);
    txn_t t;
    t.we = we; t.addr = addr; t.data = data;
    exp_q.push_back(t);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 4096; i++) rom[i] = NOP_I;
  endtask

  // Memory responder: ack on the ack_at-th request cycle, driven at the falling edge.
  always @(negedge clk) begin
    if (dmem.dmem_req && reset) begin
      if (req_cnt == ack_at - 1) begin
        dmem.dmem_ack   = 1'b1;
        dmem.dmem_rdata = mem[dmem.dmem_addr];
        if (dmem.dmem_we) mem[dmem.dmem_addr] = dmem.dmem_wdata;
        req_cnt = 0;
      end else begin
        dmem.dmem_ack = 1'b0;
        req_cnt++;
      end
    end else begin
      dmem.dmem_ack = 1'b0;
      req_cnt = 0;
    end
  end

  // Monitor: every completed access is compared against the scoreboard head.
  always @(negedge clk) begin
    #1;
    if (reset && dmem.dmem_req && dmem.dmem_ack) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_access: got we=%0b addr=0x%0h wdata=0x%0h expected no access",
                 dmem.dmem_we, dmem.dmem_addr, dmem.dmem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("dmem_we", 32'(dmem.dmem_we), 32'(mon_e.we));
        check("dmem_addr", 32'(dmem.dmem_addr), 32'(mon_e.addr));
        if (mon_e.we) check("dmem_wdata", 32'(dmem.dmem_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    check("rst_pc", 32'(imem_addr), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_req", 32'(dmem.dmem_req), 32'd0);
    check("rst_cnt", instr_count, 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic wait_pc(input string name, input logic [PW-1:0] target, input int budget);
    int k = 0;
    while (imem_addr !== target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_reach"}, 32'(imem_addr), 32'(target));
  endtask

  task automatic run_to_done(input string name, input int budget, input logic [PW-1:0] exp_pc);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_pc"}, 32'(imem_addr), 32'(exp_pc));
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Test 1: ALU ops, flags through branches, HALT instruction.
    clear_rom();
    rom[0]     = enc(OP_LDI, 3'd1, 3'd5);
    rom[1]     = enc(OP_LDI, 3'd2, 3'd3);
    rom[2]     = enc(OP_ADD, 3'd1, 3'd2);
    rom[3]     = enc(OP_ST,  3'd1, 3'd0);
    rom[4]     = enc(OP_BR,  3'd1, 3'd2);
    rom[5]     = enc(OP_BR,  3'd3, 3'd2);
    rom[6]     = enc(OP_LDI, 3'd3, 3'd7);
    rom[7]     = enc(OP_LDI, 3'd4, 3'd1);
    rom[8]     = enc(OP_SUB, 3'd4, 3'd3);
    rom[9]     = enc(OP_ST,  3'd4, 3'd2);
    rom[10]    = enc(OP_BR,  3'd3, 3'd4);
    rom[12'h20] = enc(OP_LDI, 3'd5, 3'd6);
    rom[12'h21] = enc(OP_LDI, 3'd6, 3'd3);
    rom[12'h22] = enc(OP_AND, 3'd5, 3'd6);
    rom[12'h23] = enc(OP_XOR, 3'd6, 3'd6);
    rom[12'h24] = enc(OP_BR,  3'd1, 3'd5);
    rom[12'h30] = enc(OP_ST,  3'd5, 3'd2);
    rom[12'h31] = enc(OP_BR,  3'd3, 3'd1);
    rom[12'h10] = enc(OP_BR,  3'd7, 3'd0);
    expect_txn(1'b1, 8'h00, 8'h08);
    expect_txn(1'b1, 8'h03, 8'hFA);
    expect_txn(1'b1, 8'h03, 8'h02);
    ack_at = 1;
    do_reset();
    repeat (3) @(negedge clk);
    check("t1_pc_after_3", 32'(imem_addr), 32'd3);
    wait_pc("t1_halt_pc", 12'h010, 200);
    check("t1_done_before_halt", 32'(done), 32'd0);
    @(negedge clk);
    check("t1_done_rise", 32'(done), 32'd1);
    check("t1_cnt_at_halt", instr_count, 32'(EXP_T1_CNT));
    repeat (3) @(negedge clk);
    check("t1_pc_frozen", 32'(imem_addr), 32'h010);
    check("t1_done_sticky", 32'(done), 32'd1);
    check("t1_cnt_frozen", instr_count, 32'(EXP_T1_CNT));
    check("t1_pending", 32'(exp_q.size()), 32'd0);

    // Test 2: ADD wrap to zero with carry, branch on Z, LD with immediate ack.
    clear_rom();
    rom[0]     = enc(OP_LDI, 3'd1, 3'd0);
    rom[1]     = enc(OP_LDI, 3'd2, 3'd1);
    rom[2]     = enc(OP_SUB, 3'd1, 3'd2);
    rom[3]     = enc(OP_ADD, 3'd1, 3'd2);
    rom[4]     = enc(OP_BR,  3'd1, 3'd2);
    rom[12'h40] = enc(OP_BR, 3'd3, 3'd7);
    rom[5]     = enc(OP_ST,  3'd1, 3'd1);
    rom[6]     = enc(OP_LDI, 3'd6, 3'd4);
    rom[7]     = enc(OP_LD,  3'd5, 3'd6);
    rom[8]     = enc(OP_ST,  3'd5, 3'd6);
    rom[9]     = enc(OP_BR,  3'd7, 3'd0);
    mem[4] = 8'hA5;
    expect_txn(1'b1, 8'h00, 8'h00);
    expect_txn(1'b0, 8'h04, 8'h00);
    expect_txn(1'b1, 8'h04, 8'hA5);
    do_reset();
    wait_pc("t2_br_z", 12'h040, 20);
    wait_pc("t2_ld_pc", 12'h007, 20);
    check("t2_req_idle", 32'(dmem.dmem_req), 32'd0);
    @(negedge clk);
    check("t2_req_rise", 32'(dmem.dmem_req), 32'd1);
    check("t2_pc_hold", 32'(imem_addr), 32'd7);
    @(negedge clk);
    check("t2_req_fall", 32'(dmem.dmem_req), 32'd0);
    check("t2_pc_after_ack", 32'(imem_addr), 32'd8);
    run_to_done("t2", 50, 12'h009);

    // Test 3: store with slow ack, then reset in the middle of a load.
    clear_rom();
    rom[0] = enc(OP_LDI, 3'd3, 3'd6);
    rom[1] = enc(OP_LDI, 3'd4, 3'd2);
    rom[2] = enc(OP_ST,  3'd3, 3'd4);
    rom[3] = enc(OP_LD,  3'd7, 3'd4);
    expect_txn(1'b1, 8'h02, 8'h06);
    ack_at = 3;
    do_reset();
    wait_pc("t3_st_pc", 12'h002, 10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_req_high", 32'(dmem.dmem_req), 32'd1);
      check("t3_we", 32'(dmem.dmem_we), 32'd1);
      check("t3_addr", 32'(dmem.dmem_addr), 32'h02);
      check("t3_wdata", 32'(dmem.dmem_wdata), 32'h06);
      check("t3_pc_stall", 32'(imem_addr), 32'd2);
    end
    @(negedge clk);
    ack_at = 5;
    check("t3_req_gap", 32'(dmem.dmem_req), 32'd0);
    check("t3_pc_adv", 32'(imem_addr), 32'd3);
    @(negedge clk);
    check("t3_ld_req", 32'(dmem.dmem_req), 32'd1);
    check("t3_ld_we", 32'(dmem.dmem_we), 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("t3_async_req", 32'(dmem.dmem_req), 32'd0);
    check("t3_async_pc", 32'(imem_addr), 32'd0);
    clear_rom();
    rom[0] = enc(OP_ST, 3'd7, 3'd0);
    rom[1] = enc(OP_BR, 3'd7, 3'd0);
    expect_txn(1'b1, 8'h00, 8'h00);
    ack_at = 1;
    do_reset();
    run_to_done("t3_dest", 20, 12'h001);

    // Test 4: PC wrap does not halt; straight-line code halts at HALT_ADDR.
    clear_rom();
    rom[0]      = enc(OP_BR,  3'd2, 3'd6);
    rom[12'hFFF] = enc(OP_XOR, 3'd0, 3'd0);
    rom[128]    = enc(OP_ST,  3'd1, 3'd0);
    do_reset();
    wait_pc("t4_top", 12'hFFF, 5);
    @(negedge clk);
    check("t4_wrap_pc", 32'(imem_addr), 32'd0);
    check("t4_wrap_done", 32'(done), 32'd0);
    @(negedge clk);
    check("t4_br_nz_fall", 32'(imem_addr), 32'd1);
    wait_pc("t4_halt_addr", 12'd128, 200);
    check("t4_done_before", 32'(done), 32'd0);
    @(negedge clk);
    check("t4_done_rise", 32'(done), 32'd1);
    check("t4_pc_held", 32'(imem_addr), 32'd128);
    repeat (2) @(negedge clk);
    check("t4_no_exec_req", 32'(dmem.dmem_req), 32'd0);
    check("t4_pc_frozen", 32'(imem_addr), 32'd128);
    check("t4_pending", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/core_mc.md
# core_mc

Parametrised multi-cycle successor to the single-cycle 9-bit processor top. Fetches from an external combinational instruction ROM, executes register ops in one cycle, and stalls on a req/ack data-memory handshake so that slow memories are supported. Data width, PC width and halt address are generic. A sticky `done` flag ends the program.

## Interface
- `DW`, 8: data and register width, min 4.
- `PW`, 12: program counter width.
- `HALT_ADDR`, 128: PC value that forces halt; must be < 2^PW.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `imem_addr`  out  PW: current PC; combinational copy of the PC register.
- `imem_data`  in  9: instruction at `imem_addr`, valid in the same cycle.
- `dmem_req`  out  1: data access request, registered.
- `dmem_we`  out  1: 1 = store, 0 = load; valid while `dmem_req` is high.
- `dmem_addr`  out  DW: access address.
- `dmem_wdata`  out  DW: store data.
- `dmem_rdata`  in  DW: load data, sampled in the ack cycle.
- `dmem_ack`  in  1: access complete.
- `done`  out  1: sticky halt flag.
- `instr_count`  out  32: retired-instruction counter (see Configuration).

## Operation
- Instruction fields: `[8:6]` op, `[5:3]` a, `[2:0]` b. Registers r0–r7, each DW bits. Flags Z and C.
- Op 000, ADD: ra <= ra+rb. C = carry-out, Z = (result==0).
- Op 001, SUB: ra <= ra−rb. C = borrow, Z updated.
- Op 010, AND: Z updated, C unchanged.
- Op 011, XOR: Z updated, C unchanged.
- Op 100, LDI: ra <= zero-extended b. Flags unchanged.
- Op 101, LD: ra <= mem[rb].
- Op 110, ST: mem[rb] <= ra.
- Op 111, branch/halt. b indexes BR_LUT, an 8-entry PW-bit constant table.
  - a=000: always taken.
  - a=001: taken if Z.
  - a=010: taken if !Z.
  - a=011: taken if C.
  - a=111: HALT.
  - a=100..110: NOP.
  - Taken: PC <= BR_LUT[b]. Otherwise PC <= PC+1.
- Arithmetic is modulo 2^DW. PC increment is modulo 2^PW.
- FSM states:
  - RUN: non-memory ops retire in the current cycle. LD/ST latch addr=rb, wdata=ra, we, and dest=a, then go to MEM_WAIT.
  - MEM_WAIT: `dmem_req`=1 with addr/we/wdata held stable. On `dmem_ack`: LD writes `dmem_rdata` to the latched dest, PC <= PC+1, go to RUN.
  - HALT: entered on a HALT instruction, or in RUN when PC==HALT_ADDR (that instruction does not execute). `done`=1. PC, registers, flags and memory outputs are frozen. Exit only via reset.
- `dmem_ack` outside MEM_WAIT is ignored.
- Reset values: PC=0, r0–r7=0, Z=C=0, state=RUN, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `done`=0, `instr_count`=0.

## Timing
- Non-memory instruction: 1 cycle.
- Memory instruction: 1 RUN cycle + N≥1 MEM_WAIT cycles. `dmem_req` rises the cycle after decode. An ack on the first req cycle gives a 2-cycle total.
- `dmem_req` falls the cycle after ack. Back-to-back memory ops produce one low cycle between requests.
- `done` rises one cycle after the HALT instruction or HALT_ADDR detection, and stays high.
- Reset asserted mid-MEM_WAIT: `dmem_req` drops immediately (asynchronous); no write-back occurs.
- Branch to HALT_ADDR: halt is detected on the next cycle.
- PC wrap from 2^PW−1 to 0 is legal and does not halt.

## Configuration
- `CORE_PERF_CNT_EN` defined: `instr_count` increments by 1 on every retired instruction (RUN non-memory op, ack cycle of LD/ST, and HALT). It saturates at 2^32−1.
- `CORE_PERF_CNT_EN` undefined: `instr_count` is tied to 0 and no counter flops exist.

## Structure
- Package `core_pkg` holds:
  - Opcode enum.
  - FSM state enum {RUN, MEM_WAIT, HALT}.
  - Branch-condition codes.
  - BR_LUT constant array.
- Sub-module `core_regfile`: 8×DW, two asynchronous read ports, one synchronous write port, asynchronous active-low clear.
- The top holds the FSM, ALU, flags, PC and the optional counter.

## Test plan
- Program LDI r1,5; LDI r2,3; ADD r1,r2.
  - Expect r1=8, Z=0, C=0, PC=3 after 3 cycles.
- DW=8, r1=0xFF, r2=1, ADD r1,r2.
  - Expect r1=0x00, Z=1, C=1.
  - Then BR a=001 to LUT[2]=0x40: expect PC=0x40.
- ST r3→[r4] with ack delayed 3 cycles.
  - Expect `dmem_req` high for 3 cycles with addr/wdata stable and we=1.
  - PC advances only after ack.
- LD r5←[r6], `dmem_rdata`=0xA5 with ack on the first req cycle.
  - Expect r5=0xA5 after 2 cycles total.
- Reset pulsed during MEM_WAIT.
  - Expect `dmem_req`=0 immediately, PC=0, and the destination register = 0.
- HALT at PC=7: expect `done`=1 from the next cycle, PC held at 7, `instr_count` frozen (= retired count with the macro, 0 without).
- Straight-line code reaching PC=128 (`HALT_ADDR`): expect halt without executing the instruction at 128.
